// File: rtl/hazard_unit.sv
// Pipeline hazard detector: tracks EX/MEM destination shadows and raises stall/chng2nop
// for load-use and branch-operand hazards; flush forces a bubble without stalling.
module hazard_unit (
   input  logic        clk,
   input  logic        nrst,
   input  logic [31:0] instr_in,
   input  logic        flush_in,
   output logic        stall,
   output logic        chng2nop,
   output logic [7:0]  stall_cnt
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_AUI  = 7'b0010111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [0:0] {RUN = 1'b0, STALLED = 1'b1} state_t;

   state_t      state;
   logic [4:0]  ex_rd;
   logic        ex_wr;
   logic        ex_ld;
   logic [4:0]  mem_rd;
   logic        mem_wr;
   logic        mem_ld;

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        use_rs1;
   logic        use_rs2;
   logic        wr_rd;
   logic        is_ld;
   logic        is_br;
   logic        hit_ex;
   logic        hit_mem;
   logic        load_use;
   logic        branch_alu;
   logic        branch_ld;
   logic        hazard;

   assign opcode = instr_in[6:0];
   assign rd     = instr_in[11:7];
   assign rs1    = instr_in[19:15];
   assign rs2    = instr_in[24:20];

   // Decode operand usage and destination write for the ID instruction
   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      wr_rd   = 1'b0;
      case (opcode)
         OP_R:    begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
         OP_B:    begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_S:    begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_I:    begin use_rs1 = 1'b1; wr_rd = 1'b1; end
         OP_LD:   begin use_rs1 = 1'b1; wr_rd = 1'b1; end
         OP_JALR: begin use_rs1 = 1'b1; wr_rd = 1'b1; end
         OP_LUI:  wr_rd = 1'b1;
         OP_AUI:  wr_rd = 1'b1;
         OP_JAL:  wr_rd = 1'b1;
         default: begin use_rs1 = 1'b0; use_rs2 = 1'b0; wr_rd = 1'b0; end
      endcase
      if (rd == 5'd0) begin
         wr_rd = 1'b0;
      end else begin
         wr_rd = wr_rd;
      end
   end

   assign is_ld = (opcode == OP_LD) && wr_rd;
   assign is_br = (opcode == OP_B) || (opcode == OP_JALR);

   assign hit_ex  = (ex_rd != 5'd0) &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
   assign hit_mem = (mem_rd != 5'd0) &&
                    ((use_rs1 && (rs1 == mem_rd)) || (use_rs2 && (rs2 == mem_rd)));

   assign load_use   = hit_ex && ex_ld;
   assign branch_alu = is_br && hit_ex && ex_wr && !ex_ld;
   assign branch_ld  = is_br && hit_mem && mem_ld;
   assign hazard     = load_use || branch_alu || branch_ld;

   // Flush wins: it bubbles ID without holding the front end
   assign stall    = hazard && !flush_in;
   assign chng2nop = hazard || flush_in;

   // Advance EX/MEM shadows; a held or squashed ID enters EX as a bubble
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ex_rd  <= 5'd0;
         ex_wr  <= 1'b0;
         ex_ld  <= 1'b0;
         mem_rd <= 5'd0;
         mem_wr <= 1'b0;
         mem_ld <= 1'b0;
      end else begin
         mem_rd <= ex_rd;
         mem_wr <= ex_wr;
         mem_ld <= ex_ld;
         if (!stall && !chng2nop) begin
            ex_rd <= wr_rd ? rd : 5'd0;
            ex_wr <= wr_rd;
            ex_ld <= is_ld;
         end else begin
            ex_rd <= 5'd0;
            ex_wr <= 1'b0;
            ex_ld <= 1'b0;
         end
      end
   end

   // RUN/STALLED tracking with saturating stall-cycle counter
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= RUN;
         stall_cnt <= 8'd0;
      end else begin
         case (state)
            RUN: begin
               if (stall) begin
                  state <= STALLED;
               end else begin
                  state <= RUN;
               end
            end
            STALLED: begin
               if (stall) begin
                  state <= STALLED;
               end else begin
                  state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
         if (stall && (stall_cnt != 8'd255)) begin
            stall_cnt <= stall_cnt + 8'd1;
         end else begin
            stall_cnt <= stall_cnt;
         end
      end
   end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port nrst  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port instr_in  input  `instr_size (32)  instruction currently in IF/ID, the same word presented to cu.instr_in.
REQ-004 SHALL have port flush_in  input  1  branch/jump redirect resolved this cycle; discard the instruction in ID.
REQ-005 SHALL have port stall  output  1  hold PC and IF/ID; drives cu.stall.
REQ-006 SHALL have port chng2nop  output  1  force NOP control word into ID/EX; drives cu.chng2nop.
REQ-007 SHALL have port stall_cnt  output  8  saturating count of stall cycles since reset.

Function
REQ-008 SHALL decode instr_in opcode [6:0] as follows:
- uses rs1 and rs2: rtype 0110011, btype 1100011, stype 0100011.
- uses rs1 only: itype 0010011, ldtype 0000011, jalr 1100111.
- uses neither: all other opcodes.
REQ-009 SHALL treat as writing rd: rtype, itype, ldtype, lui 0110111, auipc 0010111, jal 1101111, jalr; rd=x0 never counts as a write.
REQ-010 SHALL keep shadow registers for the EX stage (ex_rd[4:0], ex_wr, ex_ld) and the MEM stage (mem_rd[4:0], mem_wr, mem_ld).
REQ-011 SHALL, each cycle, shift the MEM shadow registers from EX, and load EX from the decoded ID instruction when stall=0 and chng2nop=0; otherwise EX loads a bubble (rd=0, wr=0, ld=0).
REQ-012 SHALL detect load-use: the ID instruction uses a source equal to ex_rd with ex_ld=1 and ex_rd!=0.
REQ-013 SHALL detect branch-ALU: the ID opcode is btype or jalr, and it uses a source equal to ex_rd with ex_wr=1, ex_ld=0 and ex_rd!=0.
REQ-014 SHALL detect branch-load: the ID opcode is btype or jalr, and it uses a source equal to mem_rd with mem_ld=1 and mem_rd!=0.
REQ-015 SHALL assert stall=1 and chng2nop=1 combinationally in any cycle where REQ-012, REQ-013 or REQ-014 holds and flush_in=0.
REQ-016 SHALL give these stall lengths: load-use 1 cycle; branch-ALU 1 cycle; branch after load 2 consecutive cycles (REQ-012 then REQ-014).
REQ-017 SHALL, when flush_in=1, drive stall=0 and chng2nop=1 regardless of any hazard; flush has priority over stall.
REQ-018 SHALL implement FSM states RUN and STALLED:
- RUN->STALLED when stall=1 at the clock edge.
- STALLED->RUN when stall=0.
- STALLED->STALLED while stall stays 1.
- The state is exported only through stall_cnt behaviour.
REQ-019 SHALL increment stall_cnt by 1 on each edge where stall=1, saturating at 255 with no wrap.
REQ-020 SHALL use no flip-flops in the stall/chng2nop path beyond the shadow registers; output latency from instr_in is 0 cycles.
REQ-021 SHALL drive stall=0 and chng2nop=0 for instr_in=0 (opcode 0000000) with empty shadows.

Reset
REQ-022 SHALL, on nrst=0, immediately clear all shadow registers to bubbles, FSM to RUN and stall_cnt to 0, giving stall=0 and chng2nop=0.
REQ-023 SHALL, when reset is asserted mid-stall, drop stall within the reset-asserted interval and resume in RUN with no residual stall after nrst rises.

Verification
REQ-024 SHALL cover: lw x4 then add x7,x4,x5 -> one cycle stall=1/chng2nop=1, add issues the next cycle, stall_cnt=1.
REQ-025 SHALL cover: lw x4 then beq x4,x2 -> stall=1 for exactly 2 cycles, stall_cnt=2.
REQ-026 SHALL cover: add x8,x0,x1 then beq x8,x3 -> 1 stall; add x0,x1,x2 then add x5,x0,x0 -> no stall.
REQ-027 SHALL cover: a load-use hazard coincident with flush_in=1 -> stall=0, chng2nop=1, and no stall in the following cycle.
REQ-028 SHALL cover: 300 back-to-back load-use pairs -> stall_cnt saturates at 255 and holds.
REQ-029 SHALL cover: nrst pulsed low during the first stall cycle of lw/beq -> stall=0 while nrst=0, stall_cnt=0, no stall after release.
